// File: rtl/nf10_axis_pkg.sv
// Shared definitions for the NetFPGA-10G AXI-Stream pipeline: tuser field offsets,
// one-hot port codes, lookup FSM states and the MAC<->DMA pairing helpers.
package nf10_axis_pkg;

    localparam int LEN_LSB = 0;
    localparam int LEN_MSB = 15;
    localparam int SRC_LSB = 16;
    localparam int SRC_MSB = 23;
    localparam int DST_LSB = 24;
    localparam int DST_MSB = 31;

    localparam logic [7:0] MAC0 = 8'h01;
    localparam logic [7:0] DMA0 = 8'h02;
    localparam logic [7:0] MAC1 = 8'h04;
    localparam logic [7:0] DMA1 = 8'h08;
    localparam logic [7:0] MAC2 = 8'h10;
    localparam logic [7:0] DMA2 = 8'h20;
    localparam logic [7:0] MAC3 = 8'h40;
    localparam logic [7:0] DMA3 = 8'h80;

    // MAC ports occupy the even bit positions.
    localparam logic [7:0] MAC_MASK = 8'h55;

    typedef enum logic [1:0] {
        HEADER  = 2'd0,
        PAYLOAD = 2'd1,
        DROP    = 2'd2
    } lookup_state_t;

    function automatic logic src_is_valid(input logic [7:0] src);
        return $onehot(src);
    endfunction

    function automatic logic [7:0] paired_port(input logic [7:0] src);
        return (|(src & MAC_MASK)) ? (src << 1) : (src >> 1);
    endfunction

endpackage

// File: rtl/nf10_axis_fifo.sv
// Synchronous FIFO with a registered-occupancy full/empty and no fall-through:
// a word written on one edge appears at rd_data only after that edge.
module nf10_axis_fifo #(
    parameter int WIDTH      = 417,
    parameter int DEPTH_BITS = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int DEPTH = 1 << DEPTH_BITS;

    logic [WIDTH-1:0]      mem [DEPTH];
    logic [DEPTH_BITS-1:0] wr_ptr;
    logic [DEPTH_BITS-1:0] rd_ptr;
    logic [DEPTH_BITS:0]   count;
    logic                  do_wr;
    logic                  do_rd;

    assign full    = (count == (DEPTH_BITS+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_wr   = wr_en & ~full;
    assign do_rd   = rd_en & ~empty;
    assign rd_data = mem[rd_ptr];

    // NOTE: the storage array has no reset; flushing only needs the pointers and
    // count cleared, and a reset on the array would stop it mapping to RAM.
    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // NOTE: every register here is updated with <= so all of them see the
    // pre-edge values of each other, whatever order the statements are in.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + 1'b1;
            if (do_rd) rd_ptr <= rd_ptr + 1'b1;
            case ({do_wr, do_rd})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/nf10_nic_output_port_lookup.sv
// NIC output-port lookup: buffers the arbiter stream, steers each packet from a MAC
// to its paired DMA port (and vice versa), and drops packets with a bad src_port.
module nf10_nic_output_port_lookup
    import nf10_axis_pkg::*;
#(
    parameter int C_M_AXIS_DATA_WIDTH  = 256,
    parameter int C_S_AXIS_DATA_WIDTH  = 256,
    parameter int C_M_AXIS_TUSER_WIDTH = 128,
    parameter int C_S_AXIS_TUSER_WIDTH = 128,
    parameter int C_FIFO_DEPTH_BITS    = 4
) (
    input  logic                              axi_aclk,
    input  logic                              axi_reset,
    input  logic [C_S_AXIS_DATA_WIDTH-1:0]    s_axis_tdata,
    input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  s_axis_tstrb,
    input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser,
    input  logic                              s_axis_tvalid,
    output logic                              s_axis_tready,
    input  logic                              s_axis_tlast,
    output logic [C_M_AXIS_DATA_WIDTH-1:0]    m_axis_tdata,
    output logic [C_M_AXIS_DATA_WIDTH/8-1:0]  m_axis_tstrb,
    output logic [C_M_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser,
    output logic                              m_axis_tvalid,
    input  logic                              m_axis_tready,
    output logic                              m_axis_tlast,
    output logic [31:0]                       pkt_fwd_count,
    output logic [31:0]                       pkt_drop_count
);

    localparam int DW     = C_S_AXIS_DATA_WIDTH;
    localparam int SW     = C_S_AXIS_DATA_WIDTH / 8;
    localparam int UW     = C_S_AXIS_TUSER_WIDTH;
    localparam int FIFO_W = DW + SW + UW + 1;

    logic [FIFO_W-1:0] wr_data;
    logic [FIFO_W-1:0] head;
    logic              full;
    logic              empty;
    logic              push;
    logic              pop;

    logic [DW-1:0]     head_data;
    logic [SW-1:0]     head_strb;
    logic [UW-1:0]     head_user;
    logic              head_last;
    logic [7:0]        head_src;
    logic              head_valid_src;
    logic [7:0]        head_dst;

    lookup_state_t     state;
    lookup_state_t     state_next;
    logic              rewrite;
    logic              fwd_inc;
    logic              drop_inc;

    assign push          = s_axis_tvalid & ~full;
    assign s_axis_tready = ~full;
    assign wr_data       = {s_axis_tlast, s_axis_tuser, s_axis_tstrb, s_axis_tdata};

    nf10_axis_fifo #(
        .WIDTH      (FIFO_W),
        .DEPTH_BITS (C_FIFO_DEPTH_BITS)
    ) u_fifo (
        .clk     (axi_aclk),
        .rst     (axi_reset),
        .wr_en   (push),
        .wr_data (wr_data),
        .rd_en   (pop),
        .rd_data (head),
        .full    (full),
        .empty   (empty)
    );

    assign head_data      = head[DW-1:0];
    assign head_strb      = head[DW +: SW];
    assign head_user      = head[DW+SW +: UW];
    assign head_last      = head[FIFO_W-1];
    assign head_src       = head_user[SRC_MSB:SRC_LSB];
    assign head_valid_src = src_is_valid(head_src);
    assign head_dst       = paired_port(head_src);

    always_ff @(posedge axi_aclk) begin
        if (axi_reset) begin
            state <= HEADER;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: every output of this block gets a default before the case so no
    // path through it leaves a signal unassigned (which would infer a latch).
    // tvalid is derived only from FIFO occupancy and state, never from tready.
    always_comb begin
        state_next    = state;
        m_axis_tvalid = 1'b0;
        pop           = 1'b0;
        rewrite       = 1'b0;
        fwd_inc       = 1'b0;
        drop_inc      = 1'b0;
        case (state)
            HEADER: begin
                if (!empty) begin
                    if (head_valid_src) begin
                        m_axis_tvalid = 1'b1;
                        rewrite       = 1'b1;
                        if (m_axis_tready) begin
                            pop = 1'b1;
                            if (head_last) fwd_inc    = 1'b1;
                            else           state_next = PAYLOAD;
                        end
                    end else begin
                        pop = 1'b1;
                        if (head_last) drop_inc   = 1'b1;
                        else           state_next = DROP;
                    end
                end
            end
            PAYLOAD: begin
                if (!empty) begin
                    m_axis_tvalid = 1'b1;
                    if (m_axis_tready) begin
                        pop = 1'b1;
                        if (head_last) begin
                            fwd_inc    = 1'b1;
                            state_next = HEADER;
                        end
                    end
                end
            end
            DROP: begin
                if (!empty) begin
                    pop = 1'b1;
                    if (head_last) begin
                        drop_inc   = 1'b1;
                        state_next = HEADER;
                    end
                end
            end
            default: state_next = HEADER;
        endcase
    end

    assign m_axis_tdata = head_data;
    assign m_axis_tstrb = head_strb;
    assign m_axis_tlast = head_last;

    always_comb begin
        m_axis_tuser = head_user;
        if (rewrite) begin
            m_axis_tuser[DST_MSB:DST_LSB] = head_dst;
        end
    end

    always_ff @(posedge axi_aclk) begin
        if (axi_reset) begin
            pkt_fwd_count  <= '0;
            pkt_drop_count <= '0;
        end else begin
            if (fwd_inc)  pkt_fwd_count  <= pkt_fwd_count + 32'd1;
            if (drop_inc) pkt_drop_count <= pkt_drop_count + 32'd1;
        end
    end

endmodule

// File: tb/tb_nf10_nic_output_port_lookup.sv
// Directed bench for the NIC output-port lookup: a scoreboard queue holds the words
// expected on m_axis, a forked monitor compares them and checks stall stability.
module tb_nf10_nic_output_port_lookup;
    import nf10_axis_pkg::*;

    typedef struct {
        logic [255:0] data;
        logic [31:0]  strb;
        logic [127:0] user;
        logic         last;
    } word_t;

    logic         axi_aclk = 1'b0;
    logic         axi_reset;
    logic [255:0] s_axis_tdata;
    logic [31:0]  s_axis_tstrb;
    logic [127:0] s_axis_tuser;
    logic         s_axis_tvalid;
    logic         s_axis_tready;
    logic         s_axis_tlast;
    logic [255:0] m_axis_tdata;
    logic [31:0]  m_axis_tstrb;
    logic [127:0] m_axis_tuser;
    logic         m_axis_tvalid;
    logic         m_axis_tready;
    logic         m_axis_tlast;
    logic [31:0]  pkt_fwd_count;
    logic [31:0]  pkt_drop_count;

    word_t exp_q[$];
    int    errors = 0;
    int    checks = 0;

    always #5 axi_aclk = ~axi_aclk;

    nf10_nic_output_port_lookup dut (
        .axi_aclk       (axi_aclk),
        .axi_reset      (axi_reset),
        .s_axis_tdata   (s_axis_tdata),
        .s_axis_tstrb   (s_axis_tstrb),
        .s_axis_tuser   (s_axis_tuser),
        .s_axis_tvalid  (s_axis_tvalid),
        .s_axis_tready  (s_axis_tready),
        .s_axis_tlast   (s_axis_tlast),
        .m_axis_tdata   (m_axis_tdata),
        .m_axis_tstrb   (m_axis_tstrb),
        .m_axis_tuser   (m_axis_tuser),
        .m_axis_tvalid  (m_axis_tvalid),
        .m_axis_tready  (m_axis_tready),
        .m_axis_tlast   (m_axis_tlast),
        .pkt_fwd_count  (pkt_fwd_count),
        .pkt_drop_count (pkt_drop_count)
    );

    task automatic check(input string tag, input logic [255:0] observed, input logic [255:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Reference decode, written bit-by-bit rather than as a shift.
    function automatic bit model_valid(input logic [7:0] src);
        int ones = 0;
        for (int i = 0; i < 8; i++) if (src[i]) ones++;
        return ones == 1;
    endfunction

    function automatic logic [7:0] model_dst(input logic [7:0] src);
        logic [7:0] dst = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (src[i]) dst[(i % 2 == 0) ? i + 1 : i - 1] = 1'b1;
        end
        return dst;
    endfunction

    task automatic send_word(input logic [7:0] src, input bit first, input bit last, input bit expect_out);
        word_t w;
        bit    accepted = 1'b0;
        int    waited = 0;
        w.data = {$urandom(), $urandom(), $urandom(), $urandom(),
                  $urandom(), $urandom(), $urandom(), $urandom()};
        w.strb = $urandom();
        w.user = {$urandom(), $urandom(), $urandom(), $urandom()};
        w.user[SRC_MSB:SRC_LSB] = src;
        w.last = last;
        s_axis_tdata  = w.data;
        s_axis_tstrb  = w.strb;
        s_axis_tuser  = w.user;
        s_axis_tlast  = w.last;
        s_axis_tvalid = 1'b1;
        while (!accepted && waited < 200) begin
            @(negedge axi_aclk);
            accepted = s_axis_tready;
            @(posedge axi_aclk);
            #1;
            waited++;
        end
        s_axis_tvalid = 1'b0;
        if (!accepted) check("s_axis_accept_timeout", accepted, 1'b1);
        if (expect_out) begin
            if (first) w.user[DST_MSB:DST_LSB] = model_dst(src);
            exp_q.push_back(w);
        end
    endtask

    task automatic send_pkt(input logic [7:0] src, input int nwords, input bit expect_out);
        for (int i = 0; i < nwords; i++) begin
            send_word(src, i == 0, i == nwords - 1, expect_out && model_valid(src));
        end
    endtask

    task automatic wait_drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 500) begin
            @(posedge axi_aclk);
            n++;
        end
        check("scoreboard_drained", exp_q.size(), 0);
        @(negedge axi_aclk);
    endtask

    task automatic monitor();
        word_t e;
        word_t snap;
        bit    stalled = 1'b0;
        forever begin
            @(negedge axi_aclk);
            if (axi_reset) begin
                stalled = 1'b0;
                continue;
            end
            if (stalled) begin
                check("stall_tvalid", m_axis_tvalid, 1'b1);
                check("stall_tdata", m_axis_tdata, snap.data);
                check("stall_tuser", m_axis_tuser, snap.user);
                check("stall_tlast", m_axis_tlast, snap.last);
            end
            if (m_axis_tvalid && m_axis_tready) begin
                check("out_was_expected", exp_q.size() != 0, 1'b1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("out_tdata", m_axis_tdata, e.data);
                    check("out_tstrb", m_axis_tstrb, e.strb);
                    check("out_tuser", m_axis_tuser, e.user);
                    check("out_tlast", m_axis_tlast, e.last);
                end
            end
            stalled   = m_axis_tvalid && !m_axis_tready;
            snap.data = m_axis_tdata;
            snap.strb = m_axis_tstrb;
            snap.user = m_axis_tuser;
            snap.last = m_axis_tlast;
        end
    endtask

    initial begin
        axi_reset     = 1'b1;
        s_axis_tdata  = '0;
        s_axis_tstrb  = '0;
        s_axis_tuser  = '0;
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        m_axis_tready = 1'b1;
        fork
            monitor();
        join_none
        repeat (3) @(posedge axi_aclk);
        #1 axi_reset = 1'b0;
        @(negedge axi_aclk);
        check("reset_m_tvalid", m_axis_tvalid, 1'b0);
        check("reset_s_tready", s_axis_tready, 1'b1);
        check("reset_fwd", pkt_fwd_count, 32'd0);
        check("reset_drop", pkt_drop_count, 32'd0);

        // 1: single-word MAC0 packet appears one cycle after acceptance
        @(posedge axi_aclk);
        #1;
        send_word(MAC0, 1'b1, 1'b1, 1'b1);
        @(negedge axi_aclk);
        check("t1_latency_tvalid", m_axis_tvalid, 1'b1);
        check("t1_dst", m_axis_tuser[DST_MSB:DST_LSB], DMA0);
        @(negedge axi_aclk);
        check("t1_fwd", pkt_fwd_count, 32'd1);
        wait_drain();

        // 2: four-word DMA1 packet, rewrite on word 0 only
        @(posedge axi_aclk);
        #1;
        send_pkt(DMA1, 4, 1'b1);
        wait_drain();
        check("t2_fwd", pkt_fwd_count, 32'd2);

        // 3: invalid src dropped, then a valid MAC1 packet
        @(posedge axi_aclk);
        #1;
        send_pkt(8'h00, 3, 1'b1);
        send_pkt(MAC1, 2, 1'b1);
        wait_drain();
        check("t3_drop", pkt_drop_count, 32'd1);
        check("t3_fwd", pkt_fwd_count, 32'd3);

        // 4: downstream stall fills the 16-word FIFO
        @(posedge axi_aclk);
        #1;
        m_axis_tready = 1'b0;
        send_pkt(MAC1, 4, 1'b1);
        send_pkt(DMA2, 4, 1'b1);
        send_pkt(MAC3, 4, 1'b1);
        send_pkt(DMA3, 4, 1'b1);
        @(negedge axi_aclk);
        check("t4_full_tready", s_axis_tready, 1'b0);
        check("t4_stall_tvalid", m_axis_tvalid, 1'b1);
        repeat (4) @(negedge axi_aclk);
        check("t4_still_full", s_axis_tready, 1'b0);
        check("t4_no_fwd_during_stall", pkt_fwd_count, 32'd3);
        @(posedge axi_aclk);
        #1;
        m_axis_tready = 1'b1;
        send_pkt(MAC2, 4, 1'b1);
        wait_drain();
        check("t4_fwd", pkt_fwd_count, 32'd8);

        // 5: multi-hot src is dropped even with tready held low
        @(posedge axi_aclk);
        #1;
        m_axis_tready = 1'b0;
        send_pkt(8'h03, 3, 1'b1);
        repeat (4) @(negedge axi_aclk);
        check("t5_drop", pkt_drop_count, 32'd2);
        check("t5_tvalid", m_axis_tvalid, 1'b0);
        check("t5_fwd", pkt_fwd_count, 32'd8);

        // 6: reset mid-packet flushes the FIFO and counters
        @(posedge axi_aclk);
        #1;
        send_word(DMA0, 1'b1, 1'b0, 1'b0);
        send_word(DMA0, 1'b0, 1'b0, 1'b0);
        @(negedge axi_aclk);
        check("t6_pre_reset_tvalid", m_axis_tvalid, 1'b1);
        @(posedge axi_aclk);
        #1 axi_reset = 1'b1;
        @(posedge axi_aclk);
        #1 axi_reset = 1'b0;
        @(negedge axi_aclk);
        check("t6_tvalid", m_axis_tvalid, 1'b0);
        check("t6_fwd", pkt_fwd_count, 32'd0);
        check("t6_drop", pkt_drop_count, 32'd0);
        check("t6_s_tready", s_axis_tready, 1'b1);
        @(posedge axi_aclk);
        #1;
        m_axis_tready = 1'b1;
        repeat (3) @(negedge axi_aclk);
        check("t6_flushed", m_axis_tvalid, 1'b0);
        @(posedge axi_aclk);
        #1;
        send_pkt(MAC3, 2, 1'b1);
        wait_drain();
        check("t6_clean_fwd", pkt_fwd_count, 32'd1);
        check("t6_clean_drop", pkt_drop_count, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
